lfsr_crc_stream: RTL and testbench
==================================

# lfsr_crc_stream

Framed, flow-controlled CRC engine: accumulates an LFSR-based CRC across multi-beat frames, takes a partial final beat via byte-keep, and presents one CRC result and byte count per frame behind a valid/ready handshake. It sits beside packet datapaths (e.g. Ethernet FCS generation and checking). It replaces free-running per-word CRC accumulation where frame boundaries, partial words and backpressure matter.

## Interface
- LFSR_WIDTH, 32, CRC width
- LFSR_POLY, 32'h04c11db7, generator polynomial
- LFSR_INIT, all ones, state at frame start
- LFSR_CONFIG, "GALOIS", "GALOIS" or "FIBONACCI"
- REVERSE, 1, bit-reversed (LSB-first) processing
- INVERT, 1, invert final CRC
- DATA_WIDTH, 64, data width; multiple of 8
- KEEP_WIDTH, DATA_WIDTH/8, byte lanes
- LEN_WIDTH, 16, frame byte-count width
- STYLE, "AUTO", passed to LFSR sub-module

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in  in  DATA_WIDTH  beat data; byte 0 = data_in[7:0], processed first
- data_in_keep  in  KEEP_WIDTH  byte enables; used on last beat only
- data_in_valid  in  1  beat valid
- data_in_last  in  1  final beat of frame
- data_in_ready  out  1  beat accepted when valid && ready
- crc_out  out  LFSR_WIDTH  frame CRC
- crc_out_len  out  LEN_WIDTH  frame length in bytes, saturating
- crc_out_valid  out  1  result valid
- crc_out_ready  in  1  result accepted when valid && ready

## Operation
- State register crc_state resets to LFSR_INIT. The byte counter resets to 0.
- Non-last accepted beat: crc_state advances over all KEEP_WIDTH bytes, ignoring keep. The counter adds KEEP_WIDTH and saturates at 2^LEN_WIDTH-1.
- Last accepted beat: n = number of contiguous ones in keep starting at bit 0. Higher set bits are ignored (0x0B gives n=2).
  - CRC is advanced over bytes 0..n-1 only.
  - crc_out = result, XOR all-ones if INVERT.
  - crc_out_len = counter + n, saturating.
  - crc_out_valid set. crc_state returns to LFSR_INIT and the counter to 0 in the same cycle.
- n=0 on the last beat: the result is the CRC of prior bytes only. A single-beat frame with keep=0 yields the INVERT-ed LFSR_INIT with len 0.
- data_in_ready = !crc_out_valid || crc_out_ready. Input stalls only while an unaccepted result is held.
- Result registers hold stable while crc_out_valid && !crc_out_ready.
- Accept result and new last beat in the same cycle: the new result loads and valid stays 1 (back-to-back, no bubble).
- Result accepted with no new last beat: valid clears next cycle.
- rst mid-frame: the partial frame is discarded, any pending result is dropped, and all state returns to reset values.

## Timing
- Reset values: crc_out=0, crc_out_len=0, crc_out_valid=0. data_in_ready=1 from the cycle after reset deasserts (combinational from valid).
- Latency: crc_out_valid is asserted the cycle after the last beat is accepted.
- Throughput: one beat per cycle, including back-to-back single-beat frames when crc_out_ready=1.
- data_in_ready is combinational from crc_out_valid/crc_out_ready. There is no combinational path from data_in_* to any output.
- Source rule: data_in_* must stay stable while valid && !ready. The block does not check this.

## Structure
- Shared package: `lfsr_pkg` holds LFSR_CONFIG string constants and a keep-to-count function (contiguous-ones count, width-generic).
- Sub-module: existing combinational `lfsr`, instantiated KEEP_WIDTH times. Instance k has DATA_WIDTH=8*(k+1) and takes crc_state plus the low k+1 bytes.
  - Non-last beats use instance KEEP_WIDTH-1.
  - The last beat muxes instance n-1, or crc_state itself when n=0.
- Top level contains: state/counter registers, output register, handshake logic, and a 2-state output FSM (EMPTY, FULL) encoded by crc_out_valid.

## Test plan
- CRC-32 default parameters, "123456789" as beat0 keep 0xFF plus beat1 byte 0x39 keep 0x01 last -> crc_out=0xCBF43926, len=9, valid one cycle later.
- Single beat 0x61 keep 0x01 last -> 0xE8B7BE43, len=1. Same beat with keep=0x00 -> 0x00000000, len=0.
- "The quick brown fox jumps over the lazy dog" as 5 full beats plus a last beat with keep 0x07 -> 0x414FA339, len=43. Repeat with keep 0x17 on the last beat -> identical result.
- Hold crc_out_ready=0 after a result, then present the next frame -> ready=0, crc_out stable. Raise ready -> first result accepted, second result follows with the correct value.
- Back-to-back single-beat 'a' frames with crc_out_ready=1 -> valid high continuously, 0xE8B7BE43 each cycle, ready never drops.
- Assert rst after beat0 of "123456789", then send the full frame again -> 0xCBF43926, len=9. Also LEN_WIDTH=4 with a 24-byte frame -> len saturates at 15.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR/CRC definitions: configuration names, output FSM states and
// the byte-keep helper used to size the final beat of a frame.
package lfsr_pkg;

    localparam string LFSR_GALOIS    = "GALOIS";
    localparam string LFSR_FIBONACCI = "FIBONACCI";

    // Widest keep vector keep_count() accepts; callers zero-extend to this.
    localparam int KEEP_MAX = 128;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Number of contiguous ones starting at bit 0; anything above the first
    // zero is ignored, so 8'b0000_1011 counts as 2.
    function automatic int unsigned keep_count(input logic [KEEP_MAX-1:0] keep);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < KEEP_MAX; i++) begin
            run = run & keep[i];
            if (run) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational LFSR step: advances state_in over every bit of data_in.
// Byte 0 is consumed first; REVERSE selects LSB-first order within a byte.
module lfsr
    import lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
    parameter string                 LFSR_CONFIG = "GALOIS",
    parameter bit                    REVERSE     = 1'b1,
    parameter int                    DATA_WIDTH  = 8,
    parameter string                 STYLE       = "AUTO"
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [LFSR_WIDTH-1:0] state_out
);

    localparam bit                    IS_GALOIS = (LFSR_CONFIG == LFSR_GALOIS);
    localparam logic [LFSR_WIDTH-1:0] POLY_REV  = {<<{LFSR_POLY}};

    if (LFSR_CONFIG != LFSR_GALOIS && LFSR_CONFIG != LFSR_FIBONACCI) begin : g_bad_config
        $error("lfsr: LFSR_CONFIG must be GALOIS or FIBONACCI");
    end

    // Only the unrolled-loop form exists; AUTO maps onto it.
    if (STYLE != "AUTO" && STYLE != "LOOP") begin : g_bad_style
        $error("lfsr: STYLE must be AUTO or LOOP");
    end

    logic [LFSR_WIDTH-1:0] state;
    logic                  fb;
    logic                  din;

    // Reflected modes keep the register bit-reversed so the result needs no
    // final reflection.
    always_comb begin
        state = state_in;
        fb    = 1'b0;
        din   = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            din = REVERSE ? data_in[i] : data_in[8*(i/8) + 7 - (i%8)];
            if (IS_GALOIS) begin
                if (REVERSE) begin
                    fb    = state[0] ^ din;
                    state = state >> 1;
                    if (fb) state ^= POLY_REV;
                end else begin
                    fb    = state[LFSR_WIDTH-1] ^ din;
                    state = state << 1;
                    if (fb) state ^= LFSR_POLY;
                end
            end else begin
                if (REVERSE) begin
                    fb = din ^ state[0];
                    for (int j = 1; j < LFSR_WIDTH; j++) begin
                        if (LFSR_POLY[LFSR_WIDTH-j]) fb ^= state[j];
                    end
                    state = {fb, state[LFSR_WIDTH-1:1]};
                end else begin
                    fb = din ^ state[LFSR_WIDTH-1];
                    for (int j = 0; j < LFSR_WIDTH-1; j++) begin
                        if (LFSR_POLY[j+1]) fb ^= state[j];
                    end
                    state = {state[LFSR_WIDTH-2:0], fb};
                end
            end
        end
        state_out = state;
    end

endmodule

// File: rtl/lfsr_crc_stream.sv
// Framed CRC engine: accumulates a CRC over multi-beat frames and emits one
// CRC plus saturating byte count per frame behind a valid/ready handshake.
//
// state     | meaning
// ----------+----------------------------------------------------------
// OUT_EMPTY | no result held; crc_out_valid low
// OUT_FULL  | result held in crc_out/crc_out_len until crc_out_ready
module lfsr_crc_stream
    import lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = '1,
    parameter string                 LFSR_CONFIG = "GALOIS",
    parameter bit                    REVERSE     = 1'b1,
    parameter bit                    INVERT      = 1'b1,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    KEEP_WIDTH  = DATA_WIDTH/8,
    parameter int                    LEN_WIDTH   = 16,
    parameter string                 STYLE       = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [KEEP_WIDTH-1:0] data_in_keep,
    input  logic                  data_in_valid,
    input  logic                  data_in_last,
    output logic                  data_in_ready,
    output logic [LFSR_WIDTH-1:0] crc_out,
    output logic [LEN_WIDTH-1:0]  crc_out_len,
    output logic                  crc_out_valid,
    input  logic                  crc_out_ready
);

    localparam int CNT_W = $clog2(KEEP_WIDTH + 1);
    localparam int SUM_W = LEN_WIDTH + CNT_W;

    if (KEEP_WIDTH * 8 != DATA_WIDTH || KEEP_WIDTH > KEEP_MAX) begin : g_bad_width
        $error("lfsr_crc_stream: DATA_WIDTH must be 8*KEEP_WIDTH, KEEP_WIDTH <= KEEP_MAX");
    end

    logic [LFSR_WIDTH-1:0] crc_state;
    logic [LEN_WIDTH-1:0]  byte_cnt;
    out_state_t            out_state;
    out_state_t            out_state_next;

    logic                  fire;
    logic                  last_fire;
    logic [CNT_W-1:0]      keep_n;
    logic [CNT_W-1:0]      addend;
    logic [SUM_W-1:0]      len_sum;
    logic [LEN_WIDTH-1:0]  len_next;
    logic [LFSR_WIDTH-1:0] last_state;
    logic [LFSR_WIDTH-1:0] lane_state [KEEP_WIDTH];

    // Instance k folds the low k+1 bytes into crc_state.
    for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_lane
        lfsr #(
            .LFSR_WIDTH (LFSR_WIDTH),
            .LFSR_POLY  (LFSR_POLY),
            .LFSR_CONFIG(LFSR_CONFIG),
            .REVERSE    (REVERSE),
            .DATA_WIDTH (8 * (k + 1)),
            .STYLE      (STYLE)
        ) u_lfsr (
            .data_in  (data_in[8*(k+1)-1:0]),
            .state_in (crc_state),
            .state_out(lane_state[k])
        );
    end

    assign crc_out_valid = (out_state == OUT_FULL);
    assign data_in_ready = !crc_out_valid || crc_out_ready;
    assign fire          = data_in_valid && data_in_ready;
    assign last_fire     = fire && data_in_last;

    always_comb begin
        keep_n     = CNT_W'(keep_count(KEEP_MAX'(data_in_keep)));
        last_state = crc_state;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (int'(keep_n) == k + 1) last_state = lane_state[k];
        end
        addend  = data_in_last ? keep_n : CNT_W'(KEEP_WIDTH);
        len_sum = SUM_W'(byte_cnt) + SUM_W'(addend);
        if (len_sum[SUM_W-1:LEN_WIDTH] != '0) begin
            len_next = '1;
        end else begin
            len_next = len_sum[LEN_WIDTH-1:0];
        end
    end

    // A result can only be taken from FULL when the consumer is ready, so a
    // simultaneous last beat keeps the FSM in FULL with no bubble.
    always_comb begin
        out_state_next = out_state;
        case (out_state)
            OUT_EMPTY: if (last_fire) out_state_next = OUT_FULL;
            OUT_FULL:  if (crc_out_ready && !last_fire) out_state_next = OUT_EMPTY;
            default:   out_state_next = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_state   <= LFSR_INIT;
            byte_cnt    <= '0;
            out_state   <= OUT_EMPTY;
            crc_out     <= '0;
            crc_out_len <= '0;
        end else begin
            out_state <= out_state_next;
            if (last_fire) begin
                crc_state   <= LFSR_INIT;
                byte_cnt    <= '0;
                crc_out     <= INVERT ? ~last_state : last_state;
                crc_out_len <= len_next;
            end else if (fire) begin
                crc_state <= lane_state[KEEP_WIDTH-1];
                byte_cnt  <= len_next;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_crc_stream.sv
// Randomized and directed bench for lfsr_crc_stream against a bytewise
// CRC-32 reference; a second instance with LEN_WIDTH=4 covers saturation.
module tb_lfsr_crc_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data_in;
    logic [7:0]  data_in_keep;
    logic        data_in_valid;
    logic        data_in_last;
    logic        data_in_ready;
    logic [31:0] crc_out;
    logic [15:0] crc_out_len;
    logic        crc_out_valid;
    logic        crc_out_ready;
    logic        data_in_ready_s;
    logic [31:0] crc_out_s;
    logic [3:0]  crc_out_len_s;
    logic        crc_out_valid_s;

    always #5 clk = ~clk;

    lfsr_crc_stream dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_keep(data_in_keep),
        .data_in_valid(data_in_valid), .data_in_last(data_in_last),
        .data_in_ready(data_in_ready),
        .crc_out(crc_out), .crc_out_len(crc_out_len),
        .crc_out_valid(crc_out_valid), .crc_out_ready(crc_out_ready)
    );

    lfsr_crc_stream #(.LEN_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_keep(data_in_keep),
        .data_in_valid(data_in_valid), .data_in_last(data_in_last),
        .data_in_ready(data_in_ready_s),
        .crc_out(crc_out_s), .crc_out_len(crc_out_len_s),
        .crc_out_valid(crc_out_valid_s), .crc_out_ready(crc_out_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned frame_q[$];
    logic [31:0]  exp_crc_q[$];
    int           exp_len_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_crc32(input byte unsigned b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c ^= {24'd0, b[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic int lead_ones(input logic [7:0] k);
        int n;
        n = 0;
        while (n < 8 && k[n]) n++;
        return n;
    endfunction

    // Output scoreboard and input-side reference model, sampled mid-cycle.
    initial begin
        logic        hold_prev;
        logic [31:0] crc_prev;
        logic [15:0] len_prev;
        logic [31:0] ec;
        int          el;
        int          n;
        hold_prev = 1'b0;
        crc_prev  = '0;
        len_prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                frame_q.delete();
                exp_crc_q.delete();
                exp_len_q.delete();
                hold_prev = 1'b0;
            end else begin
                check_eq("in_ready", data_in_ready, !crc_out_valid || crc_out_ready);
                check_eq("in_ready_sat", data_in_ready_s, !crc_out_valid_s || crc_out_ready);
                if (hold_prev) begin
                    check_eq("hold_valid", crc_out_valid, 1'b1);
                    check_eq("hold_crc", crc_out, crc_prev);
                    check_eq("hold_len", crc_out_len, len_prev);
                end
                if (crc_out_valid && crc_out_ready) begin
                    check_eq("sb_pending", exp_crc_q.size() != 0, 1'b1);
                    if (exp_crc_q.size() != 0) begin
                        ec = exp_crc_q.pop_front();
                        el = exp_len_q.pop_front();
                        check_eq("sb_crc", crc_out, ec);
                        check_eq("sb_len", crc_out_len, el);
                        check_eq("sb_valid_sat", crc_out_valid_s, 1'b1);
                        check_eq("sb_crc_sat", crc_out_s, ec);
                        check_eq("sb_len_sat", crc_out_len_s, (el > 15) ? 15 : el);
                    end
                end
                hold_prev = crc_out_valid && !crc_out_ready;
                crc_prev  = crc_out;
                len_prev  = crc_out_len;
                if (data_in_valid && data_in_ready) begin
                    n = data_in_last ? lead_ones(data_in_keep) : 8;
                    for (int i = 0; i < n; i++) frame_q.push_back(data_in[8*i +: 8]);
                    if (data_in_last) begin
                        exp_crc_q.push_back(ref_crc32(frame_q));
                        exp_len_q.push_back((frame_q.size() > 65535) ? 65535 : frame_q.size());
                        frame_q.delete();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input bit rnd_rdy);
        logic acc;
        int   waited;
        data_in       = d;
        data_in_keep  = k;
        data_in_last  = l;
        data_in_valid = 1'b1;
        if (rnd_rdy) crc_out_ready = 1'($urandom_range(0, 1));
        acc    = 1'b0;
        waited = 0;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = data_in_ready;
            tick();
            waited++;
            if (!acc && rnd_rdy) crc_out_ready = 1'($urandom_range(0, 1));
        end
        check_eq("beat_accept", acc, 1'b1);
        data_in_valid = 1'b0;
    endtask

    // Bytes beyond the frame are filled with junk; extra keep bits sit above
    // the first cleared lane so they must be ignored.
    task automatic send_frame(input byte unsigned b[$], input logic [7:0] extra, input bit rnd_rdy);
        int          nb;
        int          r;
        logic [63:0] d;
        logic [8:0]  km;
        nb = (b.size() == 0) ? 1 : (b.size() + 7) / 8;
        for (int bt = 0; bt < nb; bt++) begin
            d = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) begin
                if (bt*8 + i < b.size()) d[8*i +: 8] = b[bt*8 + i];
            end
            if (bt == nb - 1) begin
                r  = b.size() - bt*8;
                km = (9'd1 << r) - 9'd1;
                send_beat(d, km[7:0] | (r < 8 ? extra & ~km[7:0] & ~(8'd1 << r) : 8'd0), 1'b1, rnd_rdy);
            end else begin
                send_beat(d, 8'hFF, 1'b0, rnd_rdy);
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] crc, input int len);
        check_eq({tag, "_valid"}, crc_out_valid, 1'b1);
        check_eq({tag, "_crc"}, crc_out, crc);
        check_eq({tag, "_len"}, crc_out_len, len);
    endtask

    initial begin
        byte unsigned b[$];
        byte unsigned digits[$];
        byte unsigned fox[$];
        string        s;
        rst           = 1'b1;
        data_in       = '0;
        data_in_keep  = '0;
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        crc_out_ready = 1'b1;

        s = "123456789";
        for (int i = 0; i < s.len(); i++) digits.push_back(s[i]);
        s = "The quick brown fox jumps over the lazy dog";
        for (int i = 0; i < s.len(); i++) fox.push_back(s[i]);

        repeat (3) tick();
        check_eq("rst_crc", crc_out, 32'd0);
        check_eq("rst_len", crc_out_len, 16'd0);
        check_eq("rst_valid", crc_out_valid, 1'b0);
        rst = 1'b0;
        tick();
        check_eq("rst_ready", data_in_ready, 1'b1);

        send_frame(digits, 8'h00, 1'b0);
        check_result("check_123", 32'hCBF4_3926, 9);

        b = '{8'h61};
        send_frame(b, 8'h00, 1'b0);
        check_result("single_a", 32'hE8B7_BE43, 1);
        b.delete();
        send_frame(b, 8'h00, 1'b0);
        check_result("keep_zero", 32'h0000_0000, 0);

        send_frame(fox, 8'h00, 1'b0);
        check_result("fox_k07", 32'h414F_A339, 43);
        send_frame(fox, 8'h10, 1'b0);
        check_eq("fox_k17_keep", data_in_keep, 8'h17);
        check_result("fox_k17", 32'h414F_A339, 43);

        // Backpressure: hold result, present next frame, then release.
        tick();
        crc_out_ready = 1'b0;
        send_beat(64'h61, 8'h01, 1'b1, 1'b0);
        data_in       = 64'h3837_3635_3433_3231;
        data_in_keep  = 8'hFF;
        data_in_last  = 1'b0;
        data_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("bp_ready", data_in_ready, 1'b0);
            check_eq("bp_crc", crc_out, 32'hE8B7_BE43);
        end
        crc_out_ready = 1'b1;
        tick();
        check_eq("bp_drain_valid", crc_out_valid, 1'b0);
        data_in      = 64'h39;
        data_in_keep = 8'h01;
        data_in_last = 1'b1;
        tick();
        data_in_valid = 1'b0;
        check_result("bp_second", 32'hCBF4_3926, 9);

        // Back-to-back single-beat frames.
        data_in       = 64'h61;
        data_in_keep  = 8'h01;
        data_in_last  = 1'b1;
        data_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_result("b2b", 32'hE8B7_BE43, 1);
            check_eq("b2b_ready", data_in_ready, 1'b1);
        end
        data_in_valid = 1'b0;
        tick();

        // Reset mid-frame with a pending result.
        crc_out_ready = 1'b0;
        send_beat(64'h61, 8'h01, 1'b1, 1'b0);
        crc_out_ready = 1'b1;
        tick();
        crc_out_ready = 1'b0;
        send_beat(64'h61, 8'h01, 1'b1, 1'b0);
        crc_out_ready = 1'b1;
        send_beat(64'h3837_3635_3433_3231, 8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_valid", crc_out_valid, 1'b0);
        send_frame(digits, 8'h00, 1'b0);
        check_result("midrst_123", 32'hCBF4_3926, 9);

        // Saturation on the narrow-length instance.
        b = fox[0:23];
        send_frame(b, 8'h00, 1'b0);
        check_eq("sat_len", crc_out_len_s, 4'd15);
        check_eq("sat_full_len", crc_out_len, 16'd24);

        for (int f = 0; f < 40; f++) begin
            b.delete();
            repeat ($urandom_range(0, 40)) b.push_back(8'($urandom));
            send_frame(b, 8'($urandom), 1'b1);
        end
        crc_out_ready = 1'b1;
        repeat (5) tick();
        check_eq("sb_drained", exp_crc_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
